// File: rtl/aes_pkg.sv
// Shared definitions for the byte-serial AES wrapper: block geometry and controller states.
package aes_pkg;

    localparam int BLOCK_BYTES = 16;
    localparam int BLOCK_BITS  = 128;

    typedef enum logic [1:0] {
        COLLECT,
        WAIT,
        EMIT
    } state_e;

endpackage

// File: rtl/aes_shift16.sv
// 16-byte register that can be parallel-loaded or shifted left by one byte per cycle.
// OUT_BITS selects how many of the most significant bits are exposed.
module aes_shift16
    import aes_pkg::*;
#(
    parameter int OUT_BITS = BLOCK_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [BLOCK_BITS-1:0] load_data_i,
    input  logic                  shift_i,
    input  logic [7:0]            shift_byte_i,
    output logic [OUT_BITS-1:0]   data_o
);

    logic [BLOCK_BITS-1:0] data_q;
    logic [BLOCK_BITS-1:0] data_d;

    // A load wins over a shift; the controller never requests both at once.
    always_comb begin
        data_d = data_q;
        if (load_i) begin
            data_d = load_data_i;
        end else if (shift_i) begin
            data_d = {data_q[BLOCK_BITS-9:0], shift_byte_i};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q[BLOCK_BITS-1 -: OUT_BITS];

endmodule

// File: rtl/aes_byte_ctrl.sv
// Byte-stream front end for a combinational AES core: collects 16 bytes, lets the core
// settle for WAIT_CYCLES, then serialises the 16 result bytes with valid/ready flow control.
module aes_byte_ctrl
    import aes_pkg::*;
#(
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [7:0]            in_byte,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [BLOCK_BITS-1:0] aes_din,
    input  logic [BLOCK_BITS-1:0] aes_dout,
    output logic [7:0]            out_byte,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy
);

    state_e     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [3:0] wcnt_q, wcnt_d;
    logic       inFire;
    logic       outFire;
    logic       capture;

    assign in_ready  = (state_q == COLLECT) && !rst;
    assign out_valid = (state_q == EMIT);
    assign busy      = (state_q != COLLECT);
    assign inFire    = in_valid && in_ready;
    assign outFire   = out_valid && out_ready;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        wcnt_d  = wcnt_q;
        capture = 1'b0;
        case (state_q)
            COLLECT: begin
                if (inFire) begin
                    if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
                        state_d = WAIT;
                        cnt_d   = '0;
                        wcnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q + 4'd1;
                // The core is purely combinational, so its output is trusted only after the settle window.
                if (wcnt_q == 4'(WAIT_CYCLES - 1)) begin
                    capture = 1'b1;
                    state_d = EMIT;
                    cnt_d   = '0;
                end
            end
            EMIT: begin
                if (outFire) begin
                    if (cnt_q == 4'(BLOCK_BYTES - 1)) begin
                        state_d = COLLECT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = COLLECT;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            wcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            wcnt_q  <= wcnt_d;
        end
    end

    aes_shift16 #(
        .OUT_BITS(BLOCK_BITS)
    ) u_in_sr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (1'b0),
        .load_data_i ('0),
        .shift_i     (inFire),
        .shift_byte_i(in_byte),
        .data_o      (aes_din)
    );

    aes_shift16 #(
        .OUT_BITS(8)
    ) u_out_sr (
        .clk         (clk),
        .rst         (rst),
        .load_i      (capture),
        .load_data_i (aes_dout),
        .shift_i     (outFire),
        .shift_byte_i(8'h00),
        .data_o      (out_byte)
    );

endmodule

// File: tb/tb_aes_byte_ctrl.sv
// Scoreboard bench for aes_byte_ctrl driven by a behavioural AES-128 core model.
module tb_aes_byte_ctrl;

   localparam int WAIT = 2;
   localparam logic [127:0] KEY = 128'h000102030405060708090a0b0c0d0e0f;

   logic clk;
   logic rst;
   logic [7:0] in_byte;
   logic in_valid;
   logic in_ready;
   logic [127:0] aes_din;
   logic [127:0] aes_dout;
   logic [7:0] out_byte;
   logic out_valid;
   logic out_ready;
   logic busy;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   bit rstEdge = 0;
   int readyMode = 0;
   logic [7:0] sbox [256];
   bit sboxReady = 0;

   logic [127:0] blkQ[$];
   logic [7:0] expQ[$];

   aes_byte_ctrl #(.WAIT_CYCLES(WAIT)) dut (
      .clk(clk),
      .rst(rst),
      .in_byte(in_byte),
      .in_valid(in_valid),
      .in_ready(in_ready),
      .aes_din(aes_din),
      .aes_dout(aes_dout),
      .out_byte(out_byte),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .busy(busy)
   );

   // Free-running clock, 10 time units per cycle
   initial begin
      clk = 0;
      forever #5 clk = ~clk;
   end

   // Cycle counter and a record of whether reset was sampled on the latest edge
   always @(posedge clk) begin
      cyc = cyc + 1;
      rstEdge = rst;
   end

   // GF(2^8) helpers and a straightforward FIPS-197 AES-128 encryption used as the core
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p = 8'h00;
      logic [7:0] x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl1(input logic [7:0] b);
      return {b[6:0], b[7]};
   endfunction

   function automatic logic [7:0] sboxCalc(input logic [7:0] b);
      logic [7:0] inv = 8'h01;
      logic [7:0] r1, r2, r3, r4;
      for (int i = 0; i < 254; i++) inv = gmul(inv, b);
      r1 = rotl1(inv);
      r2 = rotl1(r1);
      r3 = rotl1(r2);
      r4 = rotl1(r3);
      return inv ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
   endfunction

   function automatic logic [127:0] aesEnc(input logic [127:0] pt, input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0] rcon;
      logic [7:0] s [16];
      logic [7:0] t [16];
      logic [7:0] a0, a1, a2, a3;
      logic [127:0] ct;
      for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
      rcon = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]};
            tmp[31:24] = tmp[31:24] ^ rcon;
            rcon = xtime(rcon);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
      for (int r = 1; r <= 10; r++) begin
         for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
         for (int c = 0; c < 4; c++)
            for (int row = 0; row < 4; row++)
               s[row+4*c] = t[row+4*((c+row)%4)];
         if (r != 10) begin
            for (int c = 0; c < 4; c++) begin
               a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
               s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
               s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
               s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
               s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
            end
         end
         for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
      end
      for (int i = 0; i < 16; i++) ct[127-8*i -: 8] = s[i];
      return ct;
   endfunction

   // Combinational stand-in for the AES core that the parent would instantiate
   always @(aes_din or sboxReady) begin
      aes_dout = aesEnc(aes_din, KEY);
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   task automatic finishRun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   endtask

   function automatic logic [127:0] randBlock();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic queueBlock(input logic [127:0] blk, input logic [127:0] result);
      blkQ.push_back(blk);
      for (int i = 0; i < 16; i++) expQ.push_back(result[127-8*i -: 8]);
   endtask

   // Offer nBytes of blk, most significant byte first, with random idle gaps
   task automatic applyStimulus(input logic [127:0] blk, input int nBytes, input int gapPct);
      bit accepted;
      int waited;
      for (int i = 0; i < nBytes; i++) begin
         while ($urandom_range(0, 99) < gapPct) begin
            in_valid = 0;
            in_byte = 8'($urandom);
            @(posedge clk);
            #1;
         end
         in_valid = 1;
         in_byte = blk[127-8*i -: 8];
         accepted = 0;
         waited = 0;
         while (!accepted && waited < 400) begin
            @(negedge clk);
            accepted = in_ready;
            @(posedge clk);
            #1;
            waited++;
         end
         if (!accepted) begin
            checkOutput("inReadyTimeout", 128'(0), 128'(1));
            finishRun();
         end
      end
   endtask

   // Downstream ready: always on, or a coin flip every cycle
   initial begin
      out_ready = 0;
      forever begin
         @(posedge clk);
         #1;
         out_ready = (readyMode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      end
   end

   // Monitor: compares the DUT against the scoreboard, then advances the
   // reference view to what must hold after the coming edge
   bit blkPending = 0;
   int doneCyc = 0;
   int inCnt = 0;
   int outCnt = 0;
   bit stallPrev = 0;
   logic [7:0] prevByte = 8'h00;
   logic [127:0] curBlk = '0;

   always @(negedge clk) begin
      checkOutput("inReady", 128'(in_ready), 128'(!rst && !blkPending));
      checkOutput("busy", 128'(busy), 128'(blkPending));
      checkOutput("outValid", 128'(out_valid), 128'(blkPending && (cyc >= doneCyc + 1 + WAIT)));
      if (rstEdge) begin
         checkOutput("resetDin", aes_din, 128'(0));
         checkOutput("resetOutByte", 128'(out_byte), 128'(0));
      end
      if (blkPending) checkOutput("dinHeld", aes_din, curBlk);
      if (stallPrev) checkOutput("outHold", 128'(out_byte), 128'(prevByte));
      if (out_valid && out_ready) begin
         if (expQ.size() == 0) begin
            checkOutput("outUnexpected", 128'(out_byte), 128'(0));
         end else begin
            checkOutput("outByte", 128'(out_byte), 128'(expQ.pop_front()));
         end
         outCnt++;
         if (outCnt == 16) blkPending = 0;
      end
      stallPrev = out_valid && !out_ready;
      prevByte = out_byte;
      if (in_valid && in_ready) begin
         inCnt++;
         if (inCnt == 16) begin
            inCnt = 0;
            outCnt = 0;
            blkPending = 1;
            doneCyc = cyc;
            if (blkQ.size() == 0) begin
               checkOutput("blockUnexpected", aes_din, 128'(0));
               curBlk = '0;
            end else begin
               curBlk = blkQ.pop_front();
            end
         end
      end
      if (rst) begin
         inCnt = 0;
         outCnt = 0;
         blkPending = 0;
         stallPrev = 0;
      end
   end

   // Main sequence
   initial begin
      logic [127:0] blk;
      int waited;
      rst = 1;
      in_valid = 0;
      in_byte = 8'h00;
      for (int i = 0; i < 256; i++) sbox[i] = sboxCalc(8'(i));
      sboxReady = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;

      $display("[TB] known-answer block");
      blk = 128'h00112233445566778899aabbccddeeff;
      queueBlock(blk, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
      applyStimulus(blk, 16, 0);

      $display("[TB] random blocks with gaps and backpressure");
      readyMode = 1;
      for (int b = 0; b < 6; b++) begin
         blk = randBlock();
         queueBlock(blk, aesEnc(blk, KEY));
         applyStimulus(blk, 16, 30);
      end

      $display("[TB] reset after a partial block");
      blk = randBlock();
      applyStimulus(blk, 7, 20);
      in_valid = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1 rst = 0;
      for (int b = 0; b < 3; b++) begin
         blk = randBlock();
         queueBlock(blk, aesEnc(blk, KEY));
         applyStimulus(blk, 16, 10);
      end
      in_valid = 0;

      waited = 0;
      while ((expQ.size() != 0 || blkPending) && waited < 2000) begin
         @(posedge clk);
         waited++;
      end
      if (waited >= 2000) checkOutput("drainTimeout", 128'(expQ.size()), 128'(0));
      repeat (3) @(posedge clk);
      finishRun();
   end

endmodule

// File: doc/aes_byte_ctrl.md
AES_BYTE_CTRL -- requirements
Module: aes_byte_ctrl

Interface
REQ-001 Parameter WAIT_CYCLES, default 2: number of clock cycles that the combinational AES core is given to settle before its result is captured; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on the rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 in_byte  input  8  plaintext or ciphertext byte from the upstream byte stream.
REQ-005 in_valid  input  1  in_byte is valid this cycle.
REQ-006 in_ready  output  1  block can accept a byte this cycle.
REQ-007 aes_din  output  128  assembled block, driven to the data input of the AES/AES2 core.
REQ-008 aes_dout  input  128  core result, combinational from aes_din.
REQ-009 out_byte  output  8  result byte to the downstream byte stream.
REQ-010 out_valid  output  1  out_byte is valid this cycle.
REQ-011 out_ready  input  1  downstream accepts out_byte this cycle.
REQ-012 busy  output  1  high whenever state is not COLLECT.

Function
REQ-013 The block SHALL implement three states: COLLECT, WAIT and EMIT, plus a 4-bit byte counter cnt and a 4-bit wait counter wcnt.
REQ-014 COLLECT: in_ready SHALL be 1 (combinational on state); a handshake (in_valid & in_ready) SHALL shift aes_din <= {aes_din[119:0], in_byte} and increment cnt.
REQ-015 Byte order: the first byte accepted SHALL end in aes_din[127:120] and the 16th in aes_din[7:0].
REQ-016 A handshake with cnt==15 SHALL move the state to WAIT, clear cnt and clear wcnt; in_ready SHALL be 0 from the next cycle.
REQ-017 WAIT: wcnt SHALL increment each cycle; when wcnt==WAIT_CYCLES-1, out_sr <= aes_dout, the state SHALL move to EMIT, and cnt SHALL be cleared.
REQ-018 Latency: if the 16th input handshake occurs in cycle T, out_valid SHALL first be high in cycle T+1+WAIT_CYCLES.
REQ-019 EMIT: out_valid SHALL be 1 and out_byte SHALL equal out_sr[127:120].
REQ-020 EMIT: on out_valid & out_ready, out_sr SHALL shift left by 8 and cnt SHALL increment.
REQ-021 EMIT: out_valid and out_byte SHALL hold stable while out_ready is 0.
REQ-022 The EMIT handshake with cnt==15 SHALL return the state to COLLECT with cnt=0; out_valid SHALL be 0 in the following cycle.
REQ-023 aes_din SHALL change only on COLLECT handshakes, so it is constant throughout WAIT and EMIT.
REQ-024 No overlap between blocks: in_valid asserted during WAIT or EMIT SHALL be ignored (in_ready=0); that byte is accepted in the first COLLECT cycle.
REQ-025 out_ready asserted outside EMIT SHALL have no effect.
REQ-026 A gap in in_valid mid-block SHALL leave aes_din and cnt unchanged.

Reset
REQ-027 While rst is high, on each clock edge the block SHALL set state=COLLECT, cnt=0, wcnt=0, aes_din=0, out_sr=0.
REQ-028 During reset, in_ready SHALL be forced to 0.
REQ-029 Reset values: out_valid=0, out_byte=8'h00, busy=0.
REQ-030 Reset mid-block, in any state, SHALL discard all partial input and pending output; the first byte after reset is byte 0 of a new block.

Structure
REQ-031 The shared package aes_pkg SHALL hold the state enum, BLOCK_BYTES=16 and the AES block width of 128 bits.
REQ-032 The AES/AES2 core SHALL be instantiated by the parent, not inside this block.
REQ-033 One sub-module, aes_shift16, SHALL implement the 16-byte load/shift register and SHALL be used twice: once for input assembly and once for output serialization.

Verification
REQ-034 Reset release: in_ready rises on the first cycle after rst falls; out_valid=0; busy=0.
REQ-035 AES #(4,10), key 000102..0e0f: feed bytes 00 11 22 .. ee ff back-to-back.
- Output SHALL be 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a.
- First out_valid SHALL occur at T+3 with WAIT_CYCLES=2.
REQ-036 AES2 #(8,14), key 00..1f: input 8ea2b7ca516745bfeafc49904b496089 -> output 00112233445566778899aabbccddeeff.
REQ-037 Backpressure: out_ready toggled 1-0-0-1 randomly -> 16 bytes are emitted in order with no drop or duplicate, and out_byte is stable while stalled.
REQ-038 in_valid held high through WAIT/EMIT -> those bytes are not consumed; the next block begins on return to COLLECT.
REQ-039 rst pulsed after 7 input bytes, then a full block fed -> the result matches the full block only.
